// File: rtl/aww_types_pkg.sv
// aww_types_pkg: stall command and hazard FSM state types for the pipeline control
package aww_types_pkg;
  typedef enum logic [2:0] {
    NO_STALL    = 3'd0,
    IFID_STALL  = 3'd1,
    IDEX_STALL  = 3'd2,
    EXMEM_STALL = 3'd3,
    FULL_STALL  = 3'd4
  } pipe_stall_t;
  typedef enum logic [1:0] {RUN, DWAIT, IDROP, HALTED} hazard_state_t;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating event counter
module hazard_perf_cnt #(
  parameter int W = 32
)(
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge CLK)
    if (RST) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/pc_en control; PIPE_HAZARD_PERF_EN adds event counters
module pipe_hazard_ctrl import aww_types_pkg::*; #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 32
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [REG_W-1:0]  ifid_rs,
  input  logic [REG_W-1:0]  ifid_rt,
  input  logic              idex_memREN,
  input  logic [REG_W-1:0]  idex_rd,
  input  logic              exmem_dREN,
  input  logic              exmem_dWEN,
  input  logic              exmem_branch_taken,
  input  logic              memwb_halt,
  output pipe_stall_t       pipe_stall,
  output logic              ifid_FLUSH,
  output logic              idex_FLUSH,
  output logic              exmem_FLUSH,
  output logic              memwb_FLUSH,
  output logic              pc_en,
  output logic              halt,
  output logic [PERF_W-1:0] perf_dwait,
  output logic [PERF_W-1:0] perf_loaduse,
  output logic [PERF_W-1:0] perf_imiss,
  output logic [PERF_W-1:0] perf_flush
);
  hazard_state_t state, nstate, rnext;
  pipe_stall_t rstall;
  logic lu, dm, dmx, brf, fl;
  assign lu = idex_memREN && idex_rd != '0 && (idex_rd == ifid_rs || idex_rd == ifid_rt);
  assign dm = (exmem_dREN | exmem_dWEN) & ~dhit;
  // a completing access in DWAIT is never itself pending
  assign dmx = dm & (state != DWAIT);
  assign rnext = memwb_halt ? HALTED : dmx ? DWAIT : (exmem_branch_taken & ~ihit) ? IDROP : RUN;
  assign rstall = (memwb_halt | dmx) ? FULL_STALL : exmem_branch_taken ? NO_STALL :
                  lu ? IDEX_STALL : ~ihit ? IFID_STALL : NO_STALL;
  assign brf = ~memwb_halt & ~dmx & exmem_branch_taken;
  always_comb begin
    pipe_stall = FULL_STALL;
    fl = 1'b0;
    nstate = state;
    if (state == RUN || (state == DWAIT && dhit)) begin
      pipe_stall = rstall;
      fl = brf;
      nstate = rnext;
    end else if (state == IDROP && !dm) begin
      pipe_stall = IFID_STALL;
      nstate = ihit ? RUN : IDROP;
    end
    if (RST) begin
      pipe_stall = FULL_STALL;
      fl = 1'b0;
    end
  end
  assign pc_en = pipe_stall == NO_STALL;
  assign ifid_FLUSH = fl;
  assign idex_FLUSH = fl;
  assign exmem_FLUSH = fl;
  assign memwb_FLUSH = 1'b0;
  always_ff @(posedge CLK) begin
    state <= RST ? RUN : nstate;
    halt <= RST ? 1'b0 : halt | (nstate == HALTED);
  end
`ifdef PIPE_HAZARD_PERF_EN
  logic dw_inc;
  assign dw_inc = ~RST & ((state == RUN & ~memwb_halt & dm) | (state == DWAIT & ~dhit) | (state == IDROP & dm));
  hazard_perf_cnt #(.W(PERF_W)) u_dw (.CLK(CLK), .RST(RST), .inc(dw_inc), .cnt(perf_dwait));
  hazard_perf_cnt #(.W(PERF_W)) u_lu (.CLK(CLK), .RST(RST), .inc(pipe_stall == IDEX_STALL), .cnt(perf_loaduse));
  hazard_perf_cnt #(.W(PERF_W)) u_im (.CLK(CLK), .RST(RST), .inc(pipe_stall == IFID_STALL), .cnt(perf_imiss));
  hazard_perf_cnt #(.W(PERF_W)) u_fl (.CLK(CLK), .RST(RST), .inc(fl), .cnt(perf_flush));
`else
  assign perf_dwait = '0;
  assign perf_loaduse = '0;
  assign perf_imiss = '0;
  assign perf_flush = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors, corner sequences and random stimulus against a reference model
module tb_pipe_hazard_ctrl;
  import aww_types_pkg::*;
  typedef struct {
    int mr, rd, rs, rt, r, w, dh, ih, b, h;
    pipe_stall_t st;
    int fl, pc;
  } vec_t;
  logic CLK = 0, RST = 1;
  logic ihit, dhit, memren, dren, dwen, br, mh;
  logic [4:0] rs, rt, rd;
  pipe_stall_t pipe_stall;
  logic ifid_f, idex_f, exmem_f, memwb_f, pc_en, halt;
  logic [31:0] p_dw, p_lu, p_im, p_fl;
  int total = 0, bad = 0;
  bit m_wait = 0, m_drop = 0, m_halt = 0, n_wait, n_drop, n_halt, e_dst;
  pipe_stall_t e_stall;
  logic [3:0] e_fl;
  logic e_pc;
  int c_dw = 0, c_lu = 0, c_im = 0, c_fl = 0;
  vec_t tv[15];
  always #5 CLK = ~CLK;
  pipe_hazard_ctrl #(.REG_W(5), .PERF_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .ifid_rs(rs), .ifid_rt(rt),
    .idex_memREN(memren), .idex_rd(rd), .exmem_dREN(dren), .exmem_dWEN(dwen),
    .exmem_branch_taken(br), .memwb_halt(mh), .pipe_stall(pipe_stall),
    .ifid_FLUSH(ifid_f), .idex_FLUSH(idex_f), .exmem_FLUSH(exmem_f), .memwb_FLUSH(memwb_f),
    .pc_en(pc_en), .halt(halt), .perf_dwait(p_dw), .perf_loaduse(p_lu),
    .perf_imiss(p_im), .perf_flush(p_fl)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] pexp(input int c);
`ifdef PIPE_HAZARD_PERF_EN
    return 32'(c);
`else
    return 32'(0 * c);
`endif
  endfunction
  task automatic set_in(input int mr, d, s, t, r, w, dh, ih, b, h);
    memren = 1'(mr); rd = 5'(d); rs = 5'(s); rt = 5'(t);
    dren = 1'(r); dwen = 1'(w); dhit = 1'(dh); ihit = 1'(ih); br = 1'(b); mh = 1'(h);
  endtask
  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  endtask
  // expected behaviour for the current cycle from the control rules
  task automatic model();
    bit lu_m, dm_m;
    lu_m = memren && rd != 0 && (rd == rs || rd == rt);
    dm_m = (dren || dwen) && !dhit;
    e_stall = FULL_STALL; e_fl = 4'b0; e_pc = 0; e_dst = 0;
    n_wait = m_wait; n_drop = m_drop; n_halt = m_halt;
    if (RST) begin
      n_wait = 0; n_drop = 0; n_halt = 0;
    end else if (m_halt) begin
    end else if (m_drop) begin
      if (dm_m) e_dst = 1;
      else begin
        e_stall = IFID_STALL;
        if (ihit) n_drop = 0;
      end
    end else if (m_wait && !dhit) e_dst = 1;
    else begin
      n_wait = 0;
      if (mh) n_halt = 1;
      else if (dm_m && !m_wait) begin n_wait = 1; e_dst = 1; end
      else if (br) begin e_stall = NO_STALL; e_fl = 4'b1110; e_pc = 1; n_drop = !ihit; end
      else if (lu_m) e_stall = IDEX_STALL;
      else if (!ihit) e_stall = IFID_STALL;
      else begin e_stall = NO_STALL; e_pc = 1; end
    end
  endtask
  task automatic look();
    #1;
    model();
    chk("stall", 32'(pipe_stall), 32'(e_stall));
    chk("flush", 32'({ifid_f, idex_f, exmem_f, memwb_f}), 32'(e_fl));
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("halt", 32'(halt), 32'(m_halt));
    chk("perf_dwait", p_dw, pexp(c_dw));
    chk("perf_loaduse", p_lu, pexp(c_lu));
    chk("perf_imiss", p_im, pexp(c_im));
    chk("perf_flush", p_fl, pexp(c_fl));
  endtask
  task automatic tick();
    m_wait = n_wait; m_drop = n_drop; m_halt = n_halt;
    if (RST) begin
      c_dw = 0; c_lu = 0; c_im = 0; c_fl = 0;
    end else begin
      c_dw += int'(e_dst);
      c_lu += int'(e_stall == IDEX_STALL);
      c_im += int'(e_stall == IFID_STALL);
      c_fl += int'(e_fl != 0);
    end
    @(posedge CLK);
    #1;
  endtask
  task automatic rst_pulse();
    RST = 1; idle(); look(); tick(); RST = 0;
  endtask
  initial begin
    tv[0]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, NO_STALL,   0, 1};
    tv[1]  = '{1, 5, 0, 5, 0, 0, 1, 1, 0, 0, IDEX_STALL, 0, 0};
    tv[2]  = '{1, 0, 0, 0, 0, 0, 1, 1, 0, 0, NO_STALL,   0, 1};
    tv[3]  = '{1, 7, 7, 2, 0, 0, 1, 1, 0, 0, IDEX_STALL, 0, 0};
    tv[4]  = '{1, 7, 3, 4, 0, 0, 1, 1, 0, 0, NO_STALL,   0, 1};
    tv[5]  = '{0, 5, 5, 5, 0, 0, 1, 1, 0, 0, NO_STALL,   0, 1};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, IFID_STALL, 0, 0};
    tv[7]  = '{1, 5, 5, 0, 0, 0, 1, 0, 0, 0, IDEX_STALL, 0, 0};
    tv[8]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, NO_STALL,   7, 1};
    tv[9]  = '{1, 5, 0, 5, 0, 0, 1, 1, 1, 0, NO_STALL,   7, 1};
    tv[10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, FULL_STALL, 0, 0};
    tv[11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 0, FULL_STALL, 0, 0};
    tv[12] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, NO_STALL,   0, 1};
    tv[13] = '{0, 0, 0, 0, 1, 0, 0, 1, 1, 1, FULL_STALL, 0, 0};
    tv[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, NO_STALL,   7, 1};
    idle();
    RST = 1;
    @(posedge CLK);
    #1;
    repeat (2) begin
      look();
      chk("rst_stall", 32'(pipe_stall), 32'(FULL_STALL));
      chk("rst_pc", 32'(pc_en), 32'(0));
      chk("rst_halt", 32'(halt), 32'(0));
      tick();
    end
    RST = 0;
    look();
    chk("rel_stall", 32'(pipe_stall), 32'(NO_STALL));
    chk("rel_pc", 32'(pc_en), 32'(1));
    tick();
    for (int i = 0; i < 15; i++) begin
      rst_pulse();
      set_in(tv[i].mr, tv[i].rd, tv[i].rs, tv[i].rt, tv[i].r, tv[i].w, tv[i].dh, tv[i].ih, tv[i].b, tv[i].h);
      look();
      chk($sformatf("tv%0d_stall", i), 32'(pipe_stall), 32'(tv[i].st));
      chk($sformatf("tv%0d_flush", i), 32'({ifid_f, idex_f, exmem_f}), 32'(tv[i].fl));
      chk($sformatf("tv%0d_pc", i), 32'(pc_en), 32'(tv[i].pc));
      tick();
    end
    rst_pulse();
    set_in(0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    repeat (3) begin
      look();
      chk("dwait_stall", 32'(pipe_stall), 32'(FULL_STALL));
      chk("dwait_pc", 32'(pc_en), 32'(0));
      tick();
    end
    dhit = 1;
    look();
    chk("dhit_stall", 32'(pipe_stall), 32'(NO_STALL));
    chk("dhit_pc", 32'(pc_en), 32'(1));
    tick();
    idle();
    look();
    chk("dwait_count", p_dw, pexp(3));
    tick();
    rst_pulse();
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    look();
    chk("br_flush", 32'({ifid_f, idex_f, exmem_f, memwb_f}), 32'(4'b1110));
    chk("br_pc", 32'(pc_en), 32'(1));
    tick();
    br = 0;
    repeat (2) begin
      look();
      chk("idrop_stall", 32'(pipe_stall), 32'(IFID_STALL));
      chk("idrop_pc", 32'(pc_en), 32'(0));
      chk("idrop_flush", 32'({ifid_f, idex_f, exmem_f}), 32'(0));
      tick();
    end
    ihit = 1;
    look();
    chk("discard_stall", 32'(pipe_stall), 32'(IFID_STALL));
    tick();
    look();
    chk("back_run_stall", 32'(pipe_stall), 32'(NO_STALL));
    chk("back_run_pc", 32'(pc_en), 32'(1));
    tick();
    rst_pulse();
    mh = 1;
    look();
    chk("halt_stall", 32'(pipe_stall), 32'(FULL_STALL));
    tick();
    mh = 0;
    repeat (10) begin
      ihit = 1'($urandom_range(1));
      dhit = 1'($urandom_range(1));
      look();
      chk("halted_flag", 32'(halt), 32'(1));
      chk("halted_stall", 32'(pipe_stall), 32'(FULL_STALL));
      chk("halted_pc", 32'(pc_en), 32'(0));
      tick();
    end
    rst_pulse();
    idle();
    look();
    chk("unhalt_flag", 32'(halt), 32'(0));
    chk("unhalt_stall", 32'(pipe_stall), 32'(NO_STALL));
    tick();
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(99) == 0) || (m_halt && $urandom_range(7) == 0);
      set_in(int'($urandom_range(1)), int'($urandom_range(3)), int'($urandom_range(3)),
             int'($urandom_range(3)), int'($urandom_range(3) == 0), int'($urandom_range(3) == 0),
             int'($urandom_range(2) != 0), int'($urandom_range(3) != 0), int'($urandom_range(6) == 0),
             int'(!m_wait && !m_drop && $urandom_range(63) == 0));
      look();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Producer side of the pipeline-register control interface. Generates `pipe_stall` (a `pipe_stall_t`), the four per-stage FLUSH strobes and `pc_en` from cache handshakes, load-use detection, taken branches and halt. Sits beside the pipeline registers in the datapath top and is their only driver. Holds a small FSM for data-cache waits, wrong-path fetch squash and halt.

Parameters:
REG_W, 5, register-index width for hazard compare
PERF_W, 32, width of the performance counters (used only with the optional feature)

Ports:
CLK  in  1  clock
RST  in  1  reset; synchronous, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
ifid_rs  in  REG_W  source reg 1 of the instruction in IF/ID
ifid_rt  in  REG_W  source reg 2 of the instruction in IF/ID
idex_memREN  in  1  instruction in ID/EX is a load
idex_rd  in  REG_W  load destination in ID/EX
exmem_dREN  in  1  EX/MEM instruction reads data memory
exmem_dWEN  in  1  EX/MEM instruction writes data memory
exmem_branch_taken  in  1  EX/MEM holds a resolved taken branch or jump
memwb_halt  in  1  MEM/WB holds a halt
pipe_stall  out  pipe_stall_t  stall command to the pipeline registers
ifid_FLUSH, idex_FLUSH, exmem_FLUSH, memwb_FLUSH  out  1 each  per-stage zeroing strobes
pc_en  out  1  PC may update this cycle
halt  out  1  registered, sticky halt indication
perf_dwait, perf_loaduse, perf_imiss, perf_flush  out  PERF_W each  stall/flush event counters

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Ports are `CLK` and `RST`.
- Reset: on `CLK` edge with `RST`=1, state=RUN, `halt`=0, counters=0. While `RST` is high, outputs are `pipe_stall`=FULL_STALL, all FLUSH=0, `pc_en`=0. `RST` mid-wait abandons DWAIT/IDROP immediately.
- FSM states: RUN, DWAIT, IDROP, HALTED. Outputs are combinational from state and inputs. The state register updates on `CLK`.
- Load-use hazard (`lu`): `lu` = `idex_memREN` & `idex_rd`!=0 & (`idex_rd`==`ifid_rs` | `idex_rd`==`ifid_rt`).
- dmem pending (`dm`): `dm` = (`exmem_dREN` | `exmem_dWEN`) & ~`dhit`.
- RUN priority, highest first:
  1. `memwb_halt` -> FULL_STALL, `pc_en`=0, next state HALTED.
  2. `dm` -> FULL_STALL, `pc_en`=0, next state DWAIT.
  3. `exmem_branch_taken` -> NO_STALL, `ifid_FLUSH`=`idex_FLUSH`=`exmem_FLUSH`=1, `pc_en`=1. If `ihit`=0 the wrong-path fetch is still in flight, so next state IDROP; otherwise stay in RUN.
  4. `lu` -> IDEX_STALL, `pc_en`=0.
  5. ~`ihit` -> IFID_STALL, `pc_en`=0.
  6. Otherwise NO_STALL, `pc_en`=1.
- DWAIT: FULL_STALL and `pc_en`=0 until `dhit`. In the `dhit` cycle, evaluate the RUN priority list with `dm` forced to 0, and the next state follows that evaluation. `memwb_halt` cannot arise in DWAIT because MEM/WB is frozen.
- IDROP: IFID_STALL, `pc_en`=0. On `ihit`, the returned instruction is discarded: still IFID_STALL, next state RUN. `dm` in IDROP takes FULL_STALL priority and IDROP is retained.
- HALTED: FULL_STALL, `pc_en`=0, all FLUSH=0. `halt` register is set on entry and exits only via `RST`.
- `memwb_FLUSH` is always 0; it is reserved for exception use.
- Simultaneous `lu` and taken branch: branch wins, because the stalled instruction is wrong-path.

Optional Feature:
- Macro `PIPE_HAZARD_PERF_EN`.
- Defined: four saturating PERF_W counters, each incremented once per cycle spent in the corresponding condition:
  - `perf_dwait`: FULL_STALL due to `dm`/DWAIT
  - `perf_loaduse`: IDEX_STALL
  - `perf_imiss`: IFID_STALL, including IDROP
  - `perf_flush`: cycles with any FLUSH
- Not defined: counter logic absent and perf ports tied to 0.

Decomposition:
- `pipe_stall_t` (NO_STALL=0, IFID_STALL=1, IDEX_STALL=2, EXMEM_STALL=3, FULL_STALL=4) and the FSM state enum `hazard_state_t` live in `aww_types_pkg`.
- Natural sub-module: `hazard_perf_cnt`, one saturating counter instantiated four times under the macro.

Test Plan:
- `RST`=1 for 2 cycles with `ihit`=`dhit`=1 -> FULL_STALL, `pc_en`=0, `halt`=0; first cycle after release with no hazards -> NO_STALL, `pc_en`=1.
- `idex_memREN`=1, `idex_rd`=5, `ifid_rt`=5 -> IDEX_STALL, `pc_en`=0, no FLUSH. Same with `idex_rd`=0 -> NO_STALL.
- `exmem_dREN`=1, `dhit` low for 3 cycles then high -> 3 cycles FULL_STALL in DWAIT, then NO_STALL with `pc_en`=1 on the `dhit` cycle. With the macro, `perf_dwait`=3.
- `exmem_branch_taken`=1 with `ihit`=0 -> FLUSH on ifid/idex/exmem and `pc_en`=1 for one cycle. Then IFID_STALL until `ihit`, plus one further IFID_STALL (discard), then RUN.
- `exmem_branch_taken`=1 together with load-use match -> flush asserted, `pipe_stall`=NO_STALL, not IDEX_STALL.
- `memwb_halt`=1 -> `halt`=1 next cycle, FULL_STALL held for 10 cycles regardless of `ihit`/`dhit`; `RST` pulse -> `halt`=0, state RUN.
